// File: rtl/sel_accumulator.sv
// Six-bit wrapping accumulator that adds or subtracts the sum of two 3-bit operands
// each clock, with a sticky carry/borrow flag.
module sel_accumulator (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_data1,
  input  logic [2:0] i_data2,
  input  logic [1:0] i_sel,
  output logic [5:0] o_data,
  output logic       o_overflow
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [5:0] acc;
  logic       ovf;
  logic [3:0] op_sum;
  logic [6:0] res;
  logic [5:0] acc_next;
  logic       ovf_next;

  // Bit 6 of the 7-bit result is the carry-out on add and the borrow on subtract.
  function automatic logic [6:0] acc_add(input logic [5:0] a, input logic [3:0] s);
    return {1'b0, a} + {3'b000, s};
  endfunction

  function automatic logic [6:0] acc_sub(input logic [5:0] a, input logic [3:0] s);
    return {1'b0, a} - {3'b000, s};
  endfunction

  assign op_sum = {1'b0, i_data1} + {1'b0, i_data2};

  always_comb begin
    acc_next = acc;
    ovf_next = ovf;
    res      = 7'd0;
    case (i_sel)
      OP_ADD: begin
        res      = acc_add(acc, op_sum);
        acc_next = res[5:0];
        ovf_next = ovf | res[6];
      end
      OP_SUB: begin
        res      = acc_sub(acc, op_sum);
        acc_next = res[5:0];
        ovf_next = ovf | res[6];
      end
      OP_HOLD: begin
        acc_next = acc;
        ovf_next = ovf;
      end
      OP_CLEAR: begin
        acc_next = 6'd0;
        ovf_next = 1'b0;
      end
      default: begin
        acc_next = acc;
        ovf_next = ovf;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= 6'd0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_next;
      ovf <= ovf_next;
    end
  end

  assign o_data     = acc;
  assign o_overflow = ovf;

endmodule

// File: tb/tb_sel_accumulator.sv
// Scoreboard bench for sel_accumulator: stimulus queues expected outputs, a monitor
// pops and compares them after each clock edge or asynchronous reset event.
module tb_sel_accumulator;

  logic       clk;
  logic       i_rst_n;
  logic [2:0] i_data1;
  logic [2:0] i_data2;
  logic [1:0] i_sel;
  logic [5:0] o_data;
  logic       o_overflow;

  typedef struct {
    logic [5:0] data;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   passes = 0;

  sel_accumulator dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .i_sel      (i_sel),
    .o_data     (o_data),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  // Monitor: compares one queued expectation per clock edge or reset event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_data === e.data && o_overflow === e.ovf)
          passes++;
        else
          $display("FAIL %s: got data=%0d ovf=%0b, expected data=%0d ovf=%0b at %0t",
                   e.name, o_data, o_overflow, e.data, e.ovf, $time);
      end
    end
  end

  task automatic push(input logic [5:0] d, input logic o, input string name);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b,
                      input logic [1:0] sel, input logic [5:0] ed, input logic eo,
                      input string name);
    @(negedge clk);
    i_rst_n = r;
    i_data1 = a;
    i_data2 = b;
    i_sel   = sel;
    push(ed, eo, name);
    @(posedge clk);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    push(6'd0, 1'b0, name);
    -> chk_ev;
    #2;
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_data1 = 3'd0;
    i_data2 = 3'd0;
    i_sel   = 2'b10;
    #1;
    i_rst_n = 1'b0;
    push(6'd0, 1'b0, "reset_state");
    -> chk_ev;
    #2;

    // Add 1+1 from reset: counts by 2, wraps on edge 32.
    for (int k = 1; k <= 31; k++)
      step(1'b1, 3'd1, 3'd1, 2'b00, 6'(2 * k), 1'b0, "add_ramp");
    step(1'b1, 3'd1, 3'd1, 2'b00, 6'd0, 1'b1, "add_wrap");
    step(1'b1, 3'd1, 3'd1, 2'b00, 6'd2, 1'b1, "add_sticky");

    // Build ACC = 38 with OVF = 1, then hit async reset with no edge.
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd16, 1'b1, "build38_a");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd30, 1'b1, "build38_b");
    step(1'b1, 3'd4, 3'd4, 2'b00, 6'd38, 1'b1, "build38_c");
    async_reset("async_reset_mid");
    step(1'b0, 3'd7, 3'd7, 2'b00, 6'd0, 1'b0, "reset_held_add");
    step(1'b0, 3'd1, 3'd0, 2'b01, 6'd0, 1'b0, "reset_held_sub");

    // Subtract from zero borrows immediately.
    step(1'b1, 3'd1, 3'd1, 2'b01, 6'd62, 1'b1, "sub_borrow1");
    step(1'b1, 3'd1, 3'd1, 2'b01, 6'd60, 1'b1, "sub_borrow2");

    // Max operands.
    async_reset("async_reset_2");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd14, 1'b0, "max_1");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd28, 1'b0, "max_2");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd42, 1'b0, "max_3");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd56, 1'b0, "max_4");
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd6,  1'b1, "max_wrap");

    // Hold and clear at ACC = 20, OVF = 1.
    step(1'b1, 3'd7, 3'd7, 2'b00, 6'd20, 1'b1, "build20");
    for (int k = 0; k < 5; k++)
      step(1'b1, 3'd7, 3'd5, 2'b10, 6'd20, 1'b1, "hold");
    step(1'b1, 3'd7, 3'd7, 2'b11, 6'd0, 1'b0, "clear");

    // Zero operands and stickiness at ACC = 63.
    for (int k = 1; k <= 4; k++)
      step(1'b1, 3'd7, 3'd7, 2'b00, 6'(14 * k), 1'b0, "build63_a");
    step(1'b1, 3'd7, 3'd0, 2'b00, 6'd63, 1'b0, "build63_b");
    step(1'b1, 3'd0, 3'd0, 2'b00, 6'd63, 1'b0, "zero_add");
    step(1'b1, 3'd0, 3'd0, 2'b01, 6'd63, 1'b0, "zero_sub");
    step(1'b1, 3'd1, 3'd0, 2'b00, 6'd0,  1'b1, "carry_63");
    step(1'b1, 3'd1, 3'd0, 2'b01, 6'd63, 1'b1, "sticky_sub");
    step(1'b1, 3'd0, 3'd5, 2'b01, 6'd58, 1'b1, "sub_in_range");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() == 0)
      passes++;
    else
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
